// File: rtl/dma_pkg.sv
// Shared types for the DMA configuration-port arbiter and future channel schedulers.
package dma_pkg;

  localparam int CFG_AW = 32;
  localparam int CFG_DW = 32;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic              lock;
    logic [CFG_AW-1:0] ad;
    logic [CFG_DW-1:0] wd;
  } cfg_req_t;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dma_cfg_arb_rr_pick.sv
// Rotating first-one finder: scans req_i starting at ptr_i, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  int unsigned     j_s;
  logic [IW-1:0]   jj_s;

  // First asserted request at or after the pointer wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j_s     = 32'd0;
    jj_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j_s  = (32'(ptr_i) + 32'(k)) % 32'(N_REQ);
      jj_s = IW'(j_s);
      if (!valid_o && req_i[jj_s]) begin
        valid_o    = 1'b1;
        gnt_o[jj_s] = 1'b1;
        idx_o      = jj_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/dma_cfg_arb.sv
// Round-robin arbiter sharing the DMA cfg/status register port between N_REQ requesters,
// with locked read-modify-write sequences and an optional lock timeout.
module dma_cfg_arb
  import dma_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = CFG_AW,
  parameter int DW       = CFG_DW,
  parameter int LOCK_TMO = 16
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [N_REQ-1:0]    req_cs_i,
  input  logic [N_REQ-1:0]    req_we_i,
  input  logic [N_REQ-1:0]    req_lock_i,
  input  logic [N_REQ*AW-1:0] req_ad_i,
  input  logic [N_REQ*DW-1:0] req_wd_i,
  output logic [N_REQ-1:0]    req_gnt_o,
  output logic [N_REQ-1:0]    req_rvalid_o,
  output logic [DW-1:0]       req_rd_o,
  output logic                lock_abort_o,
  output logic [AW-1:0]       c_ad_o,
  output logic                c_we_o,
  output logic                c_cs_o,
  output logic [DW-1:0]       c_wd_o,
  input  logic [DW-1:0]       c_rd_i
);

  localparam int IW       = $clog2(N_REQ);
  localparam int TW       = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;
  localparam int TMO_LAST = (LOCK_TMO > 0) ? (LOCK_TMO - 1) : 0;

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              c_cs_q, c_cs_d;
  logic              c_we_q, c_we_d;
  logic [AW-1:0]     c_ad_q, c_ad_d;
  logic [DW-1:0]     c_wd_q, c_wd_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DW-1:0]     rd_q, rd_d;

  cfg_req_t          reqs_s [N_REQ];
  cfg_req_t          sel_s;
  logic [N_REQ-1:0]  pick_gnt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_vld_s;
  logic [IW-1:0]     win_idx_s;
  logic [N_REQ-1:0]  gnt_s;
  logic              accept_s;
  logic              tmo_hit_s;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req_i   (req_cs_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_vld_s)
  );

  // Unpack the flat request buses into per-requester records.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs_s[i].cs   = req_cs_i[i];
      reqs_s[i].we   = req_we_i[i];
      reqs_s[i].lock = req_lock_i[i];
      reqs_s[i].ad   = CFG_AW'(req_ad_i[i*AW +: AW]);
      reqs_s[i].wd   = CFG_DW'(req_wd_i[i*DW +: DW]);
    end
  end

  // While locked only the owner is ever considered, so the candidate index needs no cs.
  assign win_idx_s = (state_q == LOCKED) ? owner_q : pick_idx_s;
  assign sel_s     = reqs_s[win_idx_s];

  // Grant / lock state machine.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    tmo_cnt_d = tmo_cnt_q;
    gnt_s     = '0;
    accept_s  = 1'b0;
    tmo_hit_s = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_vld_s) begin
          gnt_s    = pick_gnt_s;
          accept_s = 1'b1;
          rr_ptr_d = IW'(wrap_inc(32'(pick_idx_s), 32'(N_REQ)));
          if (sel_s.lock) begin
            state_d   = LOCKED;
            owner_d   = pick_idx_s;
            tmo_cnt_d = '0;
          end else begin
            state_d = ARB;
          end
        end else begin
          state_d = ARB;
        end
      end
      LOCKED: begin
        if (sel_s.cs) begin
          gnt_s[owner_q] = 1'b1;
          accept_s       = 1'b1;
          tmo_cnt_d      = '0;
          if (!sel_s.lock) begin
            state_d  = ARB;
            rr_ptr_d = IW'(wrap_inc(32'(owner_q), 32'(N_REQ)));
          end else begin
            state_d = LOCKED;
          end
        end else if ((LOCK_TMO != 0) && (tmo_cnt_q == TW'(TMO_LAST))) begin
          tmo_hit_s = 1'b1;
          state_d   = ARB;
          tmo_cnt_d = '0;
          rr_ptr_d  = IW'(wrap_inc(32'(owner_q), 32'(N_REQ)));
        end else if (tmo_cnt_q != {TW{1'b1}}) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Register-port stage and read-data return stage; a read in the port stage returns next cycle.
  always_comb begin
    c_cs_d   = accept_s;
    c_we_d   = accept_s & sel_s.we;
    c_ad_d   = c_ad_q;
    c_wd_d   = c_wd_q;
    rd_idx_d = rd_idx_q;
    rvalid_d = '0;
    rd_d     = rd_q;
    if (accept_s) begin
      c_ad_d   = AW'(sel_s.ad);
      c_wd_d   = DW'(sel_s.wd);
      rd_idx_d = win_idx_s;
    end else begin
      rd_idx_d = rd_idx_q;
    end
    if (c_cs_q && !c_we_q) begin
      rvalid_d[rd_idx_q] = 1'b1;
      rd_d               = c_rd_i;
    end else begin
      rd_d = rd_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      tmo_cnt_q <= '0;
      c_cs_q    <= 1'b0;
      c_we_q    <= 1'b0;
      c_ad_q    <= '0;
      c_wd_q    <= '0;
      rd_idx_q  <= '0;
      rvalid_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      tmo_cnt_q <= tmo_cnt_d;
      c_cs_q    <= c_cs_d;
      c_we_q    <= c_we_d;
      c_ad_q    <= c_ad_d;
      c_wd_q    <= c_wd_d;
      rd_idx_q  <= rd_idx_d;
      rvalid_q  <= rvalid_d;
      rd_q      <= rd_d;
    end
  end

  assign req_gnt_o    = gnt_s;
  assign lock_abort_o = tmo_hit_s;
  assign req_rvalid_o = rvalid_q;
  assign req_rd_o     = rd_q;
  assign c_cs_o       = c_cs_q;
  assign c_we_o       = c_we_q;
  assign c_ad_o       = c_ad_q;
  assign c_wd_o       = c_wd_q;

endmodule

// File: tb/tb_dma_cfg_arb.sv
// Directed vector bench for dma_cfg_arb with N_REQ=2, LOCK_TMO=4.
module tb_dma_cfg_arb;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  cs, we, lock;
  logic [31:0] ad0, ad1, wd0, wd1, crd;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rd, c_ad, c_wd;
  logic        abort, c_we, c_cs;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  dma_cfg_arb #(.N_REQ(2), .AW(32), .DW(32), .LOCK_TMO(4)) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .req_cs_i     (cs),
    .req_we_i     (we),
    .req_lock_i   (lock),
    .req_ad_i     ({ad1, ad0}),
    .req_wd_i     ({wd1, wd0}),
    .req_gnt_o    (gnt),
    .req_rvalid_o (rvalid),
    .req_rd_o     (rd),
    .lock_abort_o (abort),
    .c_ad_o       (c_ad),
    .c_we_o       (c_we),
    .c_cs_o       (c_cs),
    .c_wd_o       (c_wd),
    .c_rd_i       (crd)
  );

  typedef struct {
    logic [1:0]  cs, we, lock;
    logic [31:0] ad0, ad1, wd0, wd1, crd;
    logic [1:0]  gnt;
    logic        cc, cwe;
    logic [31:0] cad, cwd;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        ab;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic [1:0] i_cs, input logic [1:0] i_we, input logic [1:0] i_lock,
    input logic [31:0] i_ad0, input logic [31:0] i_ad1,
    input logic [31:0] i_wd0, input logic [31:0] i_wd1, input logic [31:0] i_crd,
    input logic [1:0] e_gnt, input logic e_cc, input logic e_cwe,
    input logic [31:0] e_cad, input logic [31:0] e_cwd,
    input logic [1:0] e_rv, input logic [31:0] e_rd, input logic e_ab);
    vec_t r;
    r.cs = i_cs; r.we = i_we; r.lock = i_lock;
    r.ad0 = i_ad0; r.ad1 = i_ad1; r.wd0 = i_wd0; r.wd1 = i_wd1; r.crd = i_crd;
    r.gnt = e_gnt; r.cc = e_cc; r.cwe = e_cwe; r.cad = e_cad; r.cwd = e_cwd;
    r.rv = e_rv; r.rd = e_rd; r.ab = e_ab;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] w, input logic [1:0] l,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] r);
    cs = c; we = w; lock = l; ad0 = a0; ad1 = a1; wd0 = d0; wd1 = d1; crd = r;
  endtask

  initial begin
    // idle, then single read from req0
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0, 32'h0,        2'b00,1'b0,1'b0, 32'h0,32'h0, 2'b00,32'h0,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h8,32'h0,32'h0,32'h0, 32'h0,        2'b01,1'b0,1'b0, 32'h0,32'h0, 2'b00,32'h0,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0, 32'hA5A50001, 2'b00,1'b1,1'b0, 32'h8,32'h0, 2'b00,32'h0,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0, 32'h0,        2'b00,1'b0,1'b0, 32'h8,32'h0, 2'b01,32'hA5A50001,1'b0));
    // contention: continuous writes from both, rr_ptr=1 after the read
    tbl.push_back(v(2'b11,2'b11,2'b00, 32'h20,32'h24,32'h100,32'h200, 32'h0,  2'b10,1'b0,1'b0, 32'h8,32'h0,    2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b11,2'b11,2'b00, 32'h20,32'h24,32'h100,32'h201, 32'h0,  2'b01,1'b1,1'b1, 32'h24,32'h200, 2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b11,2'b11,2'b00, 32'h20,32'h24,32'h101,32'h201, 32'h0,  2'b10,1'b1,1'b1, 32'h20,32'h100, 2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b01,2'b01,2'b00, 32'h20,32'h0,32'h101,32'h0,    32'h0,  2'b01,1'b1,1'b1, 32'h24,32'h201, 2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,       32'h0,  2'b00,1'b1,1'b1, 32'h20,32'h101, 2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,       32'h0,  2'b00,1'b0,1'b0, 32'h20,32'h101, 2'b00,32'hA5A50001,1'b0));
    // lock: req1 locked read then unlocked write to 0x10 while req0 waits
    tbl.push_back(v(2'b11,2'b00,2'b10, 32'h30,32'h10,32'h0,32'h0,     32'h0,       2'b10,1'b0,1'b0, 32'h20,32'h101, 2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b11,2'b10,2'b00, 32'h30,32'h10,32'h0,32'hBEEF,  32'h12345678,2'b10,1'b1,1'b0, 32'h10,32'h0,   2'b00,32'hA5A50001,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h30,32'h0,32'h0,32'h0,      32'h0,       2'b01,1'b1,1'b1, 32'h10,32'hBEEF,2'b10,32'h12345678,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,       32'h0BADF00D,2'b00,1'b1,1'b0, 32'h30,32'h0,   2'b00,32'h12345678,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,       32'h0,       2'b00,1'b0,1'b0, 32'h30,32'h0,   2'b01,32'h0BADF00D,1'b0));
    // timeout: req1 locks and goes idle, req0 waits, abort on 4th idle cycle
    tbl.push_back(v(2'b10,2'b00,2'b10, 32'h0,32'h40,32'h0,32'h0, 32'h0,  2'b10,1'b0,1'b0, 32'h30,32'h0, 2'b00,32'h0BADF00D,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h50,32'h0,32'h0,32'h0, 32'h44, 2'b00,1'b1,1'b0, 32'h40,32'h0, 2'b00,32'h0BADF00D,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h50,32'h0,32'h0,32'h0, 32'h0,  2'b00,1'b0,1'b0, 32'h40,32'h0, 2'b10,32'h44,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h50,32'h0,32'h0,32'h0, 32'h0,  2'b00,1'b0,1'b0, 32'h40,32'h0, 2'b00,32'h44,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h50,32'h0,32'h0,32'h0, 32'h0,  2'b00,1'b0,1'b0, 32'h40,32'h0, 2'b00,32'h44,1'b1));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h50,32'h0,32'h0,32'h0, 32'h0,  2'b01,1'b0,1'b0, 32'h40,32'h0, 2'b00,32'h44,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,  32'h55, 2'b00,1'b1,1'b0, 32'h50,32'h0, 2'b00,32'h44,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,  32'h0,  2'b00,1'b0,1'b0, 32'h50,32'h0, 2'b01,32'h55,1'b0));
    // timeout race: owner cs returns on the expiry cycle
    tbl.push_back(v(2'b10,2'b00,2'b10, 32'h0,32'h60,32'h0,32'h0,  32'h0,  2'b10,1'b0,1'b0, 32'h50,32'h0,  2'b00,32'h55,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,   32'h66, 2'b00,1'b1,1'b0, 32'h60,32'h0,  2'b00,32'h55,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,   32'h0,  2'b00,1'b0,1'b0, 32'h60,32'h0,  2'b10,32'h66,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,   32'h0,  2'b00,1'b0,1'b0, 32'h60,32'h0,  2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b11,2'b10,2'b10, 32'h70,32'h64,32'h0,32'h77,32'h0,  2'b10,1'b0,1'b0, 32'h60,32'h0,  2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h70,32'h0,32'h0,32'h0,  32'h0,  2'b00,1'b1,1'b1, 32'h64,32'h77, 2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h70,32'h0,32'h0,32'h0,  32'h0,  2'b00,1'b0,1'b0, 32'h64,32'h77, 2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b11,2'b10,2'b00, 32'h70,32'h68,32'h0,32'h88,32'h0,  2'b10,1'b0,1'b0, 32'h64,32'h77, 2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b01,2'b00,2'b00, 32'h70,32'h0,32'h0,32'h0,  32'h0,  2'b01,1'b1,1'b1, 32'h68,32'h88, 2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,   32'h99, 2'b00,1'b1,1'b0, 32'h70,32'h0,  2'b00,32'h66,1'b0));
    tbl.push_back(v(2'b00,2'b00,2'b00, 32'h0,32'h0,32'h0,32'h0,   32'h0,  2'b00,1'b0,1'b0, 32'h70,32'h0,  2'b01,32'h99,1'b0));

    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge hclk);
      drive(tbl[r].cs, tbl[r].we, tbl[r].lock, tbl[r].ad0, tbl[r].ad1, tbl[r].wd0, tbl[r].wd1, tbl[r].crd);
      #1;
      chk("gnt",    r, 32'(gnt),    32'(tbl[r].gnt));
      chk("c_cs",   r, 32'(c_cs),   32'(tbl[r].cc));
      chk("c_we",   r, 32'(c_we),   32'(tbl[r].cwe));
      chk("c_ad",   r, c_ad,        tbl[r].cad);
      chk("c_wd",   r, c_wd,        tbl[r].cwd);
      chk("rvalid", r, 32'(rvalid), 32'(tbl[r].rv));
      chk("rd",     r, rd,          tbl[r].rd);
      chk("abort",  r, 32'(abort),  32'(tbl[r].ab));
    end

    // reset in the middle of a read: nothing comes back, req1 wins first afterwards
    @(negedge hclk);
    drive(2'b01, 2'b00, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0, 32'hCAFE0001);
    #1 chk("rst_gnt_pre", 100, 32'(gnt), 32'h1);
    @(negedge hclk);
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0001);
    #1 chk("rst_ccs_pre", 101, 32'(c_cs), 32'h1);
    #1 hresetn = 1'b0;
    #1;
    chk("rst_ccs",  102, 32'(c_cs),   32'h0);
    chk("rst_cad",  102, c_ad,        32'h0);
    chk("rst_rv",   102, 32'(rvalid), 32'h0);
    chk("rst_rd",   102, rd,          32'h0);
    chk("rst_cwe",  102, 32'(c_we),   32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      #1;
      chk("rst_no_rv", 103 + k, 32'(rvalid), 32'h0);
      chk("rst_no_cs", 103 + k, 32'(c_cs),   32'h0);
    end
    @(negedge hclk);
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'hC, 32'h0, 32'h0, 32'h0);
    #1 chk("rst_gnt_req1", 106, 32'(gnt), 32'h2);
    @(negedge hclk);
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst_req1_ccs", 107, 32'(c_cs), 32'h1);
    chk("rst_req1_cad", 107, c_ad,      32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
